// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes, FSM states, width defaults.
package axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RD_ADDR      = 3'd1,
    ST_RD_DATA      = 3'd2,
    ST_WR_ADDR_DATA = 3'd3,
    ST_WR_RESP      = 3'd4,
    ST_RESP         = 3'd5
  } mst_state_t;

  // States in which the master is waiting on the responder.
  function automatic logic is_bus_wait(input mst_state_t s);
    return (s == ST_RD_ADDR) || (s == ST_RD_DATA) ||
           (s == ST_WR_ADDR_DATA) || (s == ST_WR_RESP);
  endfunction

endpackage

// File: rtl/axi_lite_master_wd.sv
// Watchdog counter: clears on transaction start, counts bus-wait cycles and
// flags expiry on the cycle the count reaches TIMEOUT_CYCLES.
module axi_lite_master_wd #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The cycle holding count TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th wait cycle.
  assign o_expired = i_count && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master bridging a request/response port to AR/R and AW/W/B.
// Optional watchdog enabled by defining AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axi_pkg::*;
#(
  parameter int ADDR_W         = AXI_ADDR_W,
  parameter int DATA_W         = AXI_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clock,
  input  logic                reset_n,
  // Request/response: a transfer happens on a cycle where valid and ready are
  // both high at the rising edge; a valid, once raised, stays up until taken.
  input  logic                io_req_valid,
  output logic                io_req_ready,
  input  logic                io_req_write,
  input  logic [ADDR_W-1:0]   io_req_addr,
  input  logic [DATA_W-1:0]   io_req_wdata,
  input  logic [DATA_W/8-1:0] io_req_wstrb,
  output logic                io_resp_valid,
  input  logic                io_resp_ready,
  output logic [DATA_W-1:0]   io_resp_rdata,
  output logic [1:0]          io_resp_code,
  output logic                io_resp_err,
  output logic                io_ram_awvalid,
  input  logic                io_ram_awready,
  output logic [ADDR_W-1:0]   io_ram_awaddr,
  output logic                io_ram_wvalid,
  input  logic                io_ram_wready,
  output logic [DATA_W-1:0]   io_ram_wdata,
  output logic [DATA_W/8-1:0] io_ram_wstrb,
  input  logic                io_ram_bvalid,
  output logic                io_ram_bready,
  input  logic [1:0]          io_ram_bresp,
  output logic                io_ram_arvalid,
  input  logic                io_ram_arready,
  output logic [ADDR_W-1:0]   io_ram_araddr,
  input  logic                io_ram_rvalid,
  output logic                io_ram_rready,
  input  logic [DATA_W-1:0]   io_ram_rdata,
  input  logic [1:0]          io_ram_rresp,
  output logic [2:0]          io_dbg_state
);

  mst_state_t          r_state;
  mst_state_t          w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_aw_done;
  logic                r_w_done;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_code;
  logic                w_aw_fin;
  logic                w_w_fin;
  logic                w_timeout;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  axi_lite_master_wd #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .i_clk     (clock),
    .i_rst_n   (reset_n),
    .i_clear   ((r_state == ST_IDLE) && io_req_valid),
    .i_count   (is_bus_wait(r_state)),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // Valids are decoded from registered state, so they drop asynchronously on reset.
  assign io_req_ready   = (r_state == ST_IDLE);
  assign io_ram_arvalid = (r_state == ST_RD_ADDR);
  assign io_ram_rready  = (r_state == ST_RD_DATA);
  assign io_ram_awvalid = (r_state == ST_WR_ADDR_DATA) && !r_aw_done;
  assign io_ram_wvalid  = (r_state == ST_WR_ADDR_DATA) && !r_w_done;
  assign io_ram_bready  = (r_state == ST_WR_RESP);
  assign io_resp_valid  = (r_state == ST_RESP);

  assign io_ram_araddr  = r_addr;
  assign io_ram_awaddr  = r_addr;
  assign io_ram_wdata   = r_wdata;
  assign io_ram_wstrb   = r_wstrb;
  assign io_resp_rdata  = r_rdata;
  assign io_resp_code   = r_code;
  assign io_resp_err    = (r_code != RESP_OKAY);
  assign io_dbg_state   = r_state;

  assign w_aw_fin = r_aw_done || io_ram_awready;
  assign w_w_fin  = r_w_done  || io_ram_wready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:         if (io_req_valid) w_next_state = io_req_write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
      ST_RD_ADDR:      if (io_ram_arready) w_next_state = ST_RD_DATA;
      ST_RD_DATA:      if (io_ram_rvalid) w_next_state = ST_RESP;
      ST_WR_ADDR_DATA: if (w_aw_fin && w_w_fin) w_next_state = ST_WR_RESP;
      ST_WR_RESP:      if (io_ram_bvalid) w_next_state = ST_RESP;
      ST_RESP:         if (io_resp_ready) w_next_state = ST_IDLE;
      default:         w_next_state = ST_IDLE;
    endcase
    // Expiry overrides any handshake landing in the same cycle.
    if (w_timeout) w_next_state = ST_RESP;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_code    <= RESP_OKAY;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (io_req_valid) begin
            r_addr    <= io_req_addr;
            r_wdata   <= io_req_wdata;
            r_wstrb   <= io_req_wstrb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        ST_RD_DATA: begin
          if (io_ram_rvalid) begin
            r_rdata <= io_ram_rdata;
            r_code  <= io_ram_rresp;
          end
        end
        ST_WR_ADDR_DATA: begin
          if (io_ram_awready) r_aw_done <= 1'b1;
          if (io_ram_wready)  r_w_done  <= 1'b1;
        end
        ST_WR_RESP: begin
          if (io_ram_bvalid) begin
            r_rdata <= '0;
            r_code  <= io_ram_bresp;
          end
        end
        default: ;
      endcase
      if (w_timeout) begin
        r_rdata <= '0;
        r_code  <= RESP_DECERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master; the bench itself plays the AXI responder.
module tb_axi_lite_master;

  logic        clock;
  logic        reset_n;
  logic        io_req_valid;
  logic        io_req_ready;
  logic        io_req_write;
  logic [31:0] io_req_addr;
  logic [31:0] io_req_wdata;
  logic [3:0]  io_req_wstrb;
  logic        io_resp_valid;
  logic        io_resp_ready;
  logic [31:0] io_resp_rdata;
  logic [1:0]  io_resp_code;
  logic        io_resp_err;
  logic        io_ram_awvalid;
  logic        io_ram_awready;
  logic [31:0] io_ram_awaddr;
  logic        io_ram_wvalid;
  logic        io_ram_wready;
  logic [31:0] io_ram_wdata;
  logic [3:0]  io_ram_wstrb;
  logic        io_ram_bvalid;
  logic        io_ram_bready;
  logic [1:0]  io_ram_bresp;
  logic        io_ram_arvalid;
  logic        io_ram_arready;
  logic [31:0] io_ram_araddr;
  logic        io_ram_rvalid;
  logic        io_ram_rready;
  logic [31:0] io_ram_rdata;
  logic [1:0]  io_ram_rresp;
  logic [2:0]  io_dbg_state;

  int checks;
  int errors;

  axi_lite_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .io_req_valid   (io_req_valid),
    .io_req_ready   (io_req_ready),
    .io_req_write   (io_req_write),
    .io_req_addr    (io_req_addr),
    .io_req_wdata   (io_req_wdata),
    .io_req_wstrb   (io_req_wstrb),
    .io_resp_valid  (io_resp_valid),
    .io_resp_ready  (io_resp_ready),
    .io_resp_rdata  (io_resp_rdata),
    .io_resp_code   (io_resp_code),
    .io_resp_err    (io_resp_err),
    .io_ram_awvalid (io_ram_awvalid),
    .io_ram_awready (io_ram_awready),
    .io_ram_awaddr  (io_ram_awaddr),
    .io_ram_wvalid  (io_ram_wvalid),
    .io_ram_wready  (io_ram_wready),
    .io_ram_wdata   (io_ram_wdata),
    .io_ram_wstrb   (io_ram_wstrb),
    .io_ram_bvalid  (io_ram_bvalid),
    .io_ram_bready  (io_ram_bready),
    .io_ram_bresp   (io_ram_bresp),
    .io_ram_arvalid (io_ram_arvalid),
    .io_ram_arready (io_ram_arready),
    .io_ram_araddr  (io_ram_araddr),
    .io_ram_rvalid  (io_ram_rvalid),
    .io_ram_rready  (io_ram_rready),
    .io_ram_rdata   (io_ram_rdata),
    .io_ram_rresp   (io_ram_rresp),
    .io_dbg_state   (io_dbg_state)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    io_req_valid = 1'b1;
    io_req_write = wr;
    io_req_addr  = addr;
    io_req_wdata = wdata;
    io_req_wstrb = wstrb;
    step();
    io_req_valid = 1'b0;
  endtask

  task automatic finish_resp();
    io_resp_ready = 1'b1;
    step();
    io_resp_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    io_req_valid = 1'b0; io_req_write = 1'b0; io_req_addr = '0;
    io_req_wdata = '0; io_req_wstrb = '0; io_resp_ready = 1'b0;
    io_ram_awready = 1'b0; io_ram_wready = 1'b0; io_ram_bvalid = 1'b0;
    io_ram_bresp = 2'b00; io_ram_arready = 1'b0; io_ram_rvalid = 1'b0;
    io_ram_rdata = '0; io_ram_rresp = 2'b00;

    // Reset state
    repeat (2) step();
    chk("rst_arvalid", io_ram_arvalid, 0);
    chk("rst_awvalid", io_ram_awvalid, 0);
    chk("rst_wvalid", io_ram_wvalid, 0);
    chk("rst_rready", io_ram_rready, 0);
    chk("rst_bready", io_ram_bready, 0);
    chk("rst_resp_valid", io_resp_valid, 0);
    chk("rst_rdata", io_resp_rdata, 0);
    chk("rst_code", io_resp_code, 0);
    chk("rst_err", io_resp_err, 0);
    reset_n = 1'b1;
    step();
    chk("rst_req_ready", io_req_ready, 1);
    chk("rst_state", io_dbg_state, 0);

    // Read 0x80000010, arready one cycle late, rdata DEADBEEF OKAY
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    chk("rd_arvalid", io_ram_arvalid, 1);
    chk("rd_araddr", io_ram_araddr, 32'h8000_0010);
    chk("rd_req_ready", io_req_ready, 0);
    step();
    chk("rd_arvalid_hold", io_ram_arvalid, 1);
    chk("rd_araddr_hold", io_ram_araddr, 32'h8000_0010);
    io_ram_arready = 1'b1;
    step();
    io_ram_arready = 1'b0;
    chk("rd_arvalid_drop", io_ram_arvalid, 0);
    chk("rd_rready", io_ram_rready, 1);
    io_ram_rvalid = 1'b1; io_ram_rdata = 32'hDEAD_BEEF; io_ram_rresp = 2'b00;
    step();
    io_ram_rvalid = 1'b0; io_ram_rdata = 32'h0;
    chk("rd_resp_valid", io_resp_valid, 1);
    chk("rd_rdata", io_resp_rdata, 32'hDEAD_BEEF);
    chk("rd_code", io_resp_code, 0);
    chk("rd_err", io_resp_err, 0);
    chk("rd_rready_drop", io_ram_rready, 0);

    // Hold resp_ready low 5 cycles while a competing request is offered
    io_req_valid = 1'b1; io_req_write = 1'b1; io_req_addr = 32'h0000_0100;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_resp_valid", io_resp_valid, 1);
      chk("hold_rdata", io_resp_rdata, 32'hDEAD_BEEF);
      chk("hold_code", io_resp_code, 0);
      chk("hold_req_ready", io_req_ready, 0);
      chk("hold_awvalid", io_ram_awvalid, 0);
    end
    io_req_valid = 1'b0;
    finish_resp();
    chk("hold_done_resp_valid", io_resp_valid, 0);
    chk("hold_done_req_ready", io_req_ready, 1);
    chk("hold_done_awvalid", io_ram_awvalid, 0);

    // Write 0x00001000, simultaneous AW/W handshake, bresp DECERR
    issue(1'b1, 32'h0000_1000, 32'hA5A5_5A5A, 4'h3);
    chk("we_awvalid", io_ram_awvalid, 1);
    chk("we_wvalid", io_ram_wvalid, 1);
    chk("we_wstrb", io_ram_wstrb, 4'h3);
    io_ram_awready = 1'b1; io_ram_wready = 1'b1;
    step();
    io_ram_awready = 1'b0; io_ram_wready = 1'b0;
    chk("we_awvalid_drop", io_ram_awvalid, 0);
    chk("we_wvalid_drop", io_ram_wvalid, 0);
    chk("we_bready", io_ram_bready, 1);
    io_ram_bvalid = 1'b1; io_ram_bresp = 2'b11;
    step();
    io_ram_bvalid = 1'b0; io_ram_bresp = 2'b00;
    chk("we_resp_valid", io_resp_valid, 1);
    chk("we_code", io_resp_code, 2'b11);
    chk("we_err", io_resp_err, 1);
    chk("we_rdata", io_resp_rdata, 0);
    finish_resp();

    // Write 0x80000004, wready two cycles before awready
    issue(1'b1, 32'h8000_0004, 32'h1234_5678, 4'hF);
    chk("wr_awaddr", io_ram_awaddr, 32'h8000_0004);
    chk("wr_wdata", io_ram_wdata, 32'h1234_5678);
    chk("wr_wstrb", io_ram_wstrb, 4'hF);
    io_ram_wready = 1'b1;
    step();
    io_ram_wready = 1'b0;
    chk("wr_wvalid_drop", io_ram_wvalid, 0);
    chk("wr_awvalid_hold1", io_ram_awvalid, 1);
    chk("wr_bready_early", io_ram_bready, 0);
    step();
    chk("wr_awvalid_hold2", io_ram_awvalid, 1);
    chk("wr_wvalid_low", io_ram_wvalid, 0);
    io_ram_awready = 1'b1;
    step();
    io_ram_awready = 1'b0;
    chk("wr_awvalid_drop", io_ram_awvalid, 0);
    chk("wr_bready", io_ram_bready, 1);
    io_ram_bvalid = 1'b1; io_ram_bresp = 2'b00;
    step();
    io_ram_bvalid = 1'b0;
    chk("wr_resp_valid", io_resp_valid, 1);
    chk("wr_code", io_resp_code, 0);
    chk("wr_err", io_resp_err, 0);
    chk("wr_bready_drop", io_ram_bready, 0);
    finish_resp();
    chk("wr_req_ready", io_req_ready, 1);

    // Reset asserted while in RD_DATA
    issue(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    io_ram_arready = 1'b1;
    step();
    io_ram_arready = 1'b0;
    chk("rr_rready", io_ram_rready, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rr_arvalid", io_ram_arvalid, 0);
    chk("rr_rready_async", io_ram_rready, 0);
    chk("rr_resp_valid", io_resp_valid, 0);
    chk("rr_state", io_dbg_state, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("rr_req_ready", io_req_ready, 1);
    chk("rr_rready_after", io_ram_rready, 0);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    // arready never comes: expect 8 cycles in RD_ADDR then DECERR response
    begin
      int n;
      n = 0;
      issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
      while (io_ram_arvalid === 1'b1 && n < 50) begin
        n++;
        step();
      end
      chk("to_cycles", n, 8);
      chk("to_resp_valid", io_resp_valid, 1);
      chk("to_code", io_resp_code, 2'b11);
      chk("to_err", io_resp_err, 1);
      chk("to_rdata", io_resp_rdata, 0);
      chk("to_arvalid", io_ram_arvalid, 0);
      finish_resp();
      chk("to_req_ready", io_req_ready, 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
